// File: rtl/camera_telemetry_tx_pkg.sv
// Shared constants and types for the camera telemetry transmitter.
// ASCII record characters, hex formatter and FSM state encoding.
`ifndef TELEM_REC_LEN
`define TELEM_REC_LEN(NH) (5 + 6 * (1 + (NH)))
`endif

package camera_telemetry_tx_pkg;

    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } telem_state_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/camera_telemetry_tx_uart_tx_byte.sv
// UART 8N1 byte transmitter, LSB first, idle high.
// ready_out rises in the final stop-bit cycle so bytes chain with no gap.
module uart_tx_byte #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx_out
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic          active;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end   = (baud_cnt == BW'(BAUD_DIV - 1));
    assign ready_out = !active || (bit_cnt == 4'd9 && bit_end);

    // Shift out start, 8 data and stop bits, each BAUD_DIV cycles long
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active   <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            shreg    <= '0;
            tx_out   <= 1'b1;
        end else if (valid_in && ready_out) begin
            active   <= 1'b1;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            shreg    <= data_in;
            tx_out   <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    tx_out  <= (bit_cnt == 4'd8) ? 1'b1 : shreg[bit_cnt[2:0]];
                end
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end
        end
    end

endmodule

// File: rtl/camera_telemetry_tx.sv
// Streams snapshots of camera pos/dir as ASCII hex records over UART.
// Records start on send_in or a periodic tick; one extra request can queue.
module camera_telemetry_tx
    import camera_telemetry_tx_pkg::*;
#(
    parameter int BAUD_DIV      = 434,
    parameter int PERIOD_CYCLES = 5_000_000,
    parameter int W             = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [2:0][W-1:0] pos_in,
    input  logic [2:0][W-1:0] dir_in,
    input  logic             periodic_in,
    input  logic             send_in,
    output logic             uart_tx_out,
    output logic             busy_out
);

    localparam int NH      = (W + 3) / 4;
    localparam int LEN     = `TELEM_REC_LEN(NH);
    localparam int IW      = $clog2(LEN + 1);
    localparam int IDX_DSP = 1 + 3 * (1 + NH);
    localparam int IDX_D   = IDX_DSP + 1;
    localparam int IDX_CR  = LEN - 2;
    localparam int IDX_LF  = LEN - 1;
    localparam int NBW     = (NH > 1) ? $clog2(NH) : 1;
    localparam int PW      = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

    telem_state_t    state, state_nxt;
    logic [IW-1:0]   idx;
    logic [2:0]      val_cnt;
    logic [NBW-1:0]  nib_cnt;
    logic            dig;
    logic            pending;
    logic [PW-1:0]   per_cnt;
    logic [W-1:0]    snap [6];

    logic            tick, trig, last, in_val;
    logic            tx_valid, tx_ready, tx_accept;
    logic            snap_en, restart;
    logic [7:0]      tx_data;
    logic [4*NH-1:0] cur_val, cur_sh;
    logic [3:0]      nib_sel;

    assign tick      = periodic_in && (per_cnt == PW'(PERIOD_CYCLES - 1));
    assign trig      = send_in || tick;
    assign last      = (idx == IW'(LEN));
    assign tx_accept = tx_valid && tx_ready;
    assign busy_out  = (state != IDLE);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and byte handoff; a queued record restarts with 'P' at once
    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        snap_en   = 1'b0;
        restart   = 1'b0;
        unique case (state)
            IDLE: begin
                if (trig) begin
                    snap_en   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                tx_valid = 1'b1;
                if (tx_ready) state_nxt = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (!last) begin
                        tx_valid = 1'b1;
                    end else if (pending || trig) begin
                        snap_en  = 1'b1;
                        restart  = 1'b1;
                        tx_valid = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Record byte for the current index
    always_comb begin
        cur_val          = '0;
        cur_val[W-1:0]   = snap[val_cnt];
        cur_sh           = cur_val >> (4 * (NH - 1 - int'(nib_cnt)));
        nib_sel          = cur_sh[3:0];
        in_val           = 1'b0;
        unique case (1'b1)
            restart:              tx_data = CH_P;
            (idx == IW'(0)):       tx_data = CH_P;
            (idx == IW'(IDX_DSP)): tx_data = CH_SP;
            (idx == IW'(IDX_D)):   tx_data = CH_D;
            (idx == IW'(IDX_CR)):  tx_data = CH_CR;
            (idx == IW'(IDX_LF)):  tx_data = CH_LF;
            default: begin
                in_val  = 1'b1;
                tx_data = dig ? hex_to_ascii(nib_sel) : CH_SP;
            end
        endcase
    end

    // Byte index and value/nibble position counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx     <= '0;
            val_cnt <= '0;
            nib_cnt <= '0;
            dig     <= 1'b0;
        end else if (snap_en) begin
            idx     <= restart ? IW'(1) : '0;
            val_cnt <= '0;
            nib_cnt <= '0;
            dig     <= 1'b0;
        end else if (tx_accept) begin
            idx <= idx + IW'(1);
            if (in_val) begin
                if (!dig) begin
                    dig     <= 1'b1;
                    nib_cnt <= '0;
                end else if (nib_cnt == NBW'(NH - 1)) begin
                    dig     <= 1'b0;
                    nib_cnt <= '0;
                    val_cnt <= val_cnt + 3'd1;
                end else begin
                    nib_cnt <= nib_cnt + NBW'(1);
                end
            end
        end
    end

    // One-deep request queue; a restart consumes it
    always_ff @(posedge clk_in) begin
        if (rst_in)       pending <= 1'b0;
        else if (restart) pending <= pending && trig;
        else              pending <= pending || (trig && state != IDLE);
    end

    // Free-running period counter, held at zero while disabled
    always_ff @(posedge clk_in) begin
        if (rst_in || !periodic_in) per_cnt <= '0;
        else if (tick)              per_cnt <= '0;
        else                        per_cnt <= per_cnt + PW'(1);
    end

    // Capture the camera state at record start
    always_ff @(posedge clk_in) begin
        if (snap_en) begin
            for (int i = 0; i < 3; i++) begin
                snap[i]     <= pos_in[i];
                snap[i + 3] <= dir_in[i];
            end
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .data_in   (tx_data),
        .valid_in  (tx_valid),
        .ready_out (tx_ready),
        .tx_out    (uart_tx_out)
    );

endmodule

// File: tb/tb_camera_telemetry_tx.sv
// Bench for camera_telemetry_tx: UART line decoder plus directed records.
// Expected record text is written out by hand per vector.
module tb_camera_telemetry_tx;

    localparam int BD  = 4;
    localparam int PER = 1000;
    localparam int W   = 32;
    localparam int RL  = 59;
    localparam int RC  = RL * 10 * BD;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0][31:0] pos = '0;
    logic [2:0][31:0] dir = '0;
    logic             periodic = 1'b0;
    logic             send = 1'b0;
    logic             tx;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_err = 0;
    logic [7:0] rxq [$];
    int         rxt [$];

    camera_telemetry_tx #(
        .BAUD_DIV(BD), .PERIOD_CYCLES(PER), .W(W)
    ) dut (
        .clk_in(clk), .rst_in(rst), .pos_in(pos), .dir_in(dir),
        .periodic_in(periodic), .send_in(send),
        .uart_tx_out(tx), .busy_out(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART line decoder, sampling mid-bit on falling clock edges
    initial begin : mon
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                int t0;
                logic [7:0] b;
                t0 = cyc;
                b = '0;
                repeat (2) @(negedge clk);
                if (tx === 1'b0) begin
                    for (int k = 0; k < 8; k++) begin
                        repeat (BD) @(negedge clk);
                        b[k] = tx;
                    end
                    repeat (BD) @(negedge clk);
                    if (tx !== 1'b1) frame_err++;
                    rxq.push_back(b);
                    rxt.push_back(t0);
                end
            end
        end
    end

    typedef struct {
        logic [2:0][31:0] pos;
        logic [2:0][31:0] dir;
        bit               scr;
        string            exp;
    } vec_t;

    vec_t vt [3];

    function automatic vec_t mk(input logic [31:0] px, py, pz, dx, dy, dz,
                                input bit scr, input string e);
        vec_t v;
        v.pos[0] = px; v.pos[1] = py; v.pos[2] = pz;
        v.dir[0] = dx; v.dir[1] = dy; v.dir[2] = dz;
        v.scr = scr;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
        end
    endtask

    function automatic string rec_text(input int base);
        string s;
        s = "";
        for (int i = 0; i < RL - 2; i++)
            if (base + i < rxq.size()) s = $sformatf("%s%c", s, rxq[base + i]);
        return s;
    endfunction

    function automatic int rx_at(input int i);
        return (i < rxq.size()) ? int'(rxq[i]) : -1;
    endfunction

    function automatic int rt_at(input int i);
        return (i < rxt.size()) ? rxt[i] : -1;
    endfunction

    task automatic check_rec(input string nm, input int base, input string exp);
        chk_s({nm, " text"}, rec_text(base), exp);
        chk({nm, " CR"}, rx_at(base + RL - 2), 13);
        chk({nm, " LF"}, rx_at(base + RL - 1), 10);
    endtask

    task automatic pulse_send(output int ts);
        @(posedge clk);
        #1 send = 1'b1;
        ts = cyc;
        @(posedge clk);
        #1 send = 1'b0;
    endtask

    task automatic wait_busy_low(input int bound, input bit scr, output int td);
        td = -1;
        for (int k = 0; k < bound; k++) begin
            if (scr) pos = {$urandom, $urandom, $urandom};
            @(negedge clk);
            if (busy === 1'b0) begin
                td = cyc;
                break;
            end
        end
    endtask

    task automatic run_vec(input int n, input string nm);
        int ts, td;
        rxq.delete();
        rxt.delete();
        pos = vt[n].pos;
        dir = vt[n].dir;
        pulse_send(ts);
        @(negedge clk);
        chk({nm, " busy after trigger"}, busy, 1);
        wait_busy_low(3000, vt[n].scr, td);
        chk({nm, " busy cycles"}, td - ts, RC + 2);
        chk({nm, " bytes"}, rxq.size(), RL);
        chk({nm, " start latency"}, rt_at(0) - ts, 2);
        check_rec(nm, 0, vt[n].exp);
    endtask

    initial begin
        int ts, td, tp, lows;

        vt[0] = mk(32'h0, 32'h00010000, 32'hFFFE8000, 32'h0, 32'h0, 32'h00010000, 1'b0,
                   "P 00000000 00010000 FFFE8000 D 00000000 00000000 00010000");
        vt[1] = mk(32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF,
                   32'h0F0F0F0F, 32'hA5A55A5A, 32'h80000000, 1'b0,
                   "P 12345678 9ABCDEF0 FFFFFFFF D 0F0F0F0F A5A55A5A 80000000");
        vt[2] = mk(32'hDEADBEEF, 32'h00000001, 32'h7FFFFFFF,
                   32'hC0FFEE00, 32'h00ABCDEF, 32'h10203040, 1'b1,
                   "P DEADBEEF 00000001 7FFFFFFF D C0FFEE00 00ABCDEF 10203040");

        // Reset and quiet line
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset busy", busy, 0);
        lows = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("idle line low samples", lows, 0);
        chk("idle bytes", rxq.size(), 0);

        // Table of single records, last one scrambles pos_in mid-record
        for (int n = 0; n < 3; n++) run_vec(n, $sformatf("vec%0d", n));

        // Collapsed requests during a record give exactly one follow-on
        rxq.delete();
        rxt.delete();
        pos = vt[1].pos;
        dir = vt[1].dir;
        pulse_send(ts);
        repeat (200) @(posedge clk);
        #1;
        pos = {32'h33333333, 32'h22222222, 32'h11111111};
        dir = {32'h66666666, 32'h55555555, 32'h44444444};
        repeat (100) @(posedge clk);
        pulse_send(td);
        repeat (300) @(posedge clk);
        pulse_send(td);
        repeat (100) @(posedge clk);
        #1 periodic = 1'b1;
        repeat (1100) @(posedge clk);
        #1 periodic = 1'b0;
        wait_busy_low(6000, 1'b0, td);
        chk("queue busy cycles", td - ts, 2 * RC + 2);
        repeat (3000) @(negedge clk);
        chk("queue bytes", rxq.size(), 2 * RL);
        chk("queue start latency", rt_at(0) - ts, 2);
        chk("queue back-to-back", rt_at(RL) - rt_at(RL - 1), 10 * BD);
        check_rec("queue rec0", 0, vt[1].exp);
        check_rec("queue rec1", RL,
                  "P 11111111 22222222 33333333 D 44444444 55555555 66666666");

        // Periodic records longer than the period run continuously
        rxq.delete();
        rxt.delete();
        pos = vt[0].pos;
        dir = vt[0].dir;
        @(posedge clk);
        #1 periodic = 1'b1;
        tp = cyc;
        repeat (9500) @(posedge clk);
        #1 periodic = 1'b0;
        wait_busy_low(8000, 1'b0, td);
        chk("periodic busy end", td - tp, 1001 + 5 * RC);
        repeat (200) @(negedge clk);
        chk("periodic bytes", rxq.size(), 5 * RL);
        chk("periodic first start", rt_at(0) - tp, 1001);
        for (int r = 1; r < 5; r++)
            chk($sformatf("periodic spacing %0d", r),
                rt_at(r * RL) - rt_at((r - 1) * RL), RC);
        for (int r = 0; r < 5; r++)
            check_rec($sformatf("periodic rec%0d", r), r * RL, vt[0].exp);

        // Reset during byte 20 aborts, then a clean record follows
        rxq.delete();
        rxt.delete();
        pos = vt[1].pos;
        dir = vt[1].dir;
        pulse_send(ts);
        repeat (814) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort bytes before reset", rxq.size(), 20);
        @(negedge clk);
        chk("abort tx", tx, 1);
        chk("abort busy", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        run_vec(1, "after abort");

        chk("framing errors", frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
